fifo_rptr_empty: RTL and testbench
==================================

Name: fifo_rptr_empty

Overview:
Read-side pointer and empty-flag generator for the async FIFO; the counterpart of the write-pointer/full block. It lives entirely in the read clock domain. It advances a binary read pointer on accepted reads and drives the RAM read address. It exports a Gray-coded read pointer for synchronisation into the write domain. It derives empty, almost-empty, fill level and underflow from the write pointer, which arrives already synchronised into the read domain.

Parameters:
ADRRSIZE, 3, RAM address width; pointers are ADRRSIZE+1 bits (MSB = wrap bit).
AEMPTY_THRESH, 1, raempty asserts when the fill level is <= this value; legal range 0..2^ADRRSIZE-1.

Ports:
rclk  input  1  read-domain clock; all state on rising edge.
rrst  input  1  synchronous active-high reset.
rinc  input  1  read request; accepted only when rempty=0.
rq2_wptr  input  ADRRSIZE+1  Gray write pointer, 2-flop synchronised into rclk.
raddr  output  ADRRSIZE  RAM read address = rbin[ADRRSIZE-1:0].
rptr_gray  output  ADRRSIZE+1  registered Gray read pointer, sent to the write-domain synchroniser.
rempty  output  1  registered empty flag.
raempty  output  1  registered almost-empty flag.
rcount  output  ADRRSIZE+1  registered fill level as seen from the read side (0..2^ADRRSIZE).
rundf  output  1  sticky underflow flag.

Behaviour:
- Interface: one clock (rclk); reset is synchronous and active-high (rrst).
- Reset (rrst=1 at a rising edge, overriding all other inputs):
  - rbin=0, rptr_gray=0, raddr=0.
  - rempty=1, raempty=1, rcount=0, rundf=0.
- Accept: ren = rinc & ~rempty.
- Next pointer:
  - rbin_next = rbin + ren, modulo 2^(ADRRSIZE+1); wraps from all-ones to 0 with no special case.
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
- Registers each edge: rbin <= rbin_next; rptr_gray <= rgray_next. Only one Gray bit changes per edge.
- raddr is combinational from the rbin register. The RAM word at raddr is the current head. A read is consumed at the edge where ren=1, and raddr advances one cycle later.
- rempty <= (rgray_next == rq2_wptr), a full-width compare on all ADRRSIZE+1 bits, fully parametric. It deasserts one rclk after rq2_wptr changes. It asserts in the same edge as the last accepted read.
- rcount <= gray2bin(rq2_wptr) - rbin_next, modulo 2^(ADRRSIZE+1).
- raempty <= (that same next-count value <= AEMPTY_THRESH).
- rundf <= rundf | (rinc & rempty). It is cleared only by rrst. rbin does not move on an underflowing request.
- Synchroniser lag: rq2_wptr lags the true write pointer, so rempty, raempty and rcount are pessimistic (they may report fewer entries than actually exist, never more). With a correct writer, rcount never exceeds 2^ADRRSIZE.
- Simultaneous events:
  - rinc and an rq2_wptr change in the same cycle: both are applied; empty and count use rbin_next together with the new rq2_wptr.
  - rinc while rempty=1: rejected, rundf set, pointer holds.
- Reset mid-operation: state returns to reset values at the next edge regardless of rinc or the rq2_wptr value. The writer side must be reset consistently by system convention.
- No combinational path from rinc to rempty, raempty, rcount or rptr_gray; all flags are registered.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parameterised by width;
  - default ADRRSIZE constant, shared with the write-pointer block and the FIFO top.
- One natural sub-module: gray2bin_conv, a combinational XOR-prefix converter of width ADRRSIZE+1, used for rq2_wptr. It is reusable by the write side for a wcount output.
- Everything else stays in fifo_rptr_empty.

Test Plan:
All scenarios use ADRRSIZE=3, AEMPTY_THRESH=1.
1. Reset: hold rrst=1 for 2 edges with rinc=1 and rq2_wptr=4'b0010 -> rempty=1, raempty=1, rptr_gray=0, raddr=0, rcount=0, rundf=0.
2. Fill visibility: after reset, drive rq2_wptr=gray(3)=4'b0010 with rinc=0 -> next edge rempty=0, rcount=3, raempty=0; rptr_gray stays 0.
3. Drain: continue from 2 and pulse rinc for 3 cycles -> raddr steps 0,1,2; rcount 2,1,0; raempty=1 after the second read; rempty=1 after the third read; final rptr_gray=4'b0010.
4. Underflow: with rempty=1, assert rinc for 1 cycle -> rbin and raddr unchanged, rundf=1. rundf stays 1 through later normal reads and clears only on rrst.
5. Wrap: step rq2_wptr to gray(9)=4'b1101 while reading 8 entries -> after 8 reads rptr_gray=4'b1100 (gray 8), raddr=0, rempty=0, rcount=1. After 16 total reads with rq2_wptr=gray(0)=4'b0000 -> rptr_gray=0, rempty=1, rcount=0.
6. Reset mid-operation: rcount=2, rinc=1, rrst=1 in the same cycle -> next edge all reset values, with no pointer increment.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and Gray/binary helpers.
package fifo_pkg;

    localparam int unsigned ADRRSIZE_DFLT = 3;

    // Helper width; narrower pointers are zero-extended in and truncated back out.
    localparam int unsigned FUNC_W = 32;

    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Upper zero bits contribute nothing to the prefix XOR, so any narrower width works.
    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        logic              acc;
        b   = '0;
        acc = 1'b0;
        for (int i = FUNC_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer and empty/almost-empty/count/underflow generation for the async FIFO.
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned ADRRSIZE      = ADRRSIZE_DFLT,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADRRSIZE:0]   rq2_wptr,
    output logic [ADRRSIZE-1:0] raddr,
    output logic [ADRRSIZE:0]   rptr_gray,
    output logic                rempty,
    output logic                raempty,
    output logic [ADRRSIZE:0]   rcount,
    output logic                rundf
);

    localparam int unsigned PW = ADRRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] rq2_wbin;
    logic [PW-1:0] rcount_next;
    logic          ren;

    gray2bin_conv #(.W(PW)) u_wptr_conv (
        .gray (rq2_wptr),
        .bin  (rq2_wbin)
    );

    // Next-state pointer, flag and count terms; all use the post-read pointer.
    always_comb begin
        ren         = rinc & ~rempty;
        rbin_next   = rbin + PW'(ren);
        rgray_next  = PW'(bin2gray(FUNC_W'(rbin_next)));
        rcount_next = rq2_wbin - rbin_next;
    end

    assign raddr = rbin[ADRRSIZE-1:0];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin      <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
            raempty   <= 1'b1;
            rcount    <= '0;
            rundf     <= 1'b0;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= rgray_next;
            rempty    <= (rgray_next == rq2_wptr);
            raempty   <= (rcount_next <= PW'(AEMPTY_THRESH));
            rcount    <= rcount_next;
            rundf     <= rundf | (rinc & rempty);
        end
    end

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty with ADRRSIZE=3, AEMPTY_THRESH=1.
module tb_fifo_rptr_empty;

    logic       rclk;
    logic       rrst;
    logic       rinc;
    logic [3:0] rq2_wptr;
    logic [2:0] raddr;
    logic [3:0] rptr_gray;
    logic       rempty;
    logic       raempty;
    logic [3:0] rcount;
    logic       rundf;

    int checks = 0;
    int errors = 0;

    logic [3:0] gray_tab [0:15] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    fifo_rptr_empty #(.ADRRSIZE(3), .AEMPTY_THRESH(1)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rinc      (rinc),
        .rq2_wptr  (rq2_wptr),
        .raddr     (raddr),
        .rptr_gray (rptr_gray),
        .rempty    (rempty),
        .raempty   (raempty),
        .rcount    (rcount),
        .rundf     (rundf)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rempty"},    32'(rempty),    32'd1);
        check({tag, "_raempty"},   32'(raempty),   32'd1);
        check({tag, "_rptr_gray"}, 32'(rptr_gray), 32'd0);
        check({tag, "_raddr"},     32'(raddr),     32'd0);
        check({tag, "_rcount"},    32'(rcount),    32'd0);
        check({tag, "_rundf"},     32'(rundf),     32'd0);
    endtask

    initial begin
        int wi;

        // Reset held for two edges with active-looking inputs
        rrst     = 1'b1;
        rinc     = 1'b1;
        rq2_wptr = 4'b0010;
        tick();
        tick();
        check_reset_state("reset");

        // Three entries become visible
        rrst = 1'b0;
        rinc = 1'b0;
        tick();
        check("fill_rempty",    32'(rempty),    32'd0);
        check("fill_rcount",    32'(rcount),    32'd3);
        check("fill_raempty",   32'(raempty),   32'd0);
        check("fill_rptr_gray", 32'(rptr_gray), 32'd0);

        // Drain three entries
        check("drain0_raddr", 32'(raddr), 32'd0);
        rinc = 1'b1;
        tick();
        check("drain1_raddr",   32'(raddr),   32'd1);
        check("drain1_rcount",  32'(rcount),  32'd2);
        check("drain1_raempty", 32'(raempty), 32'd0);
        check("drain1_rempty",  32'(rempty),  32'd0);
        tick();
        check("drain2_raddr",   32'(raddr),   32'd2);
        check("drain2_rcount",  32'(rcount),  32'd1);
        check("drain2_raempty", 32'(raempty), 32'd1);
        check("drain2_rempty",  32'(rempty),  32'd0);
        tick();
        check("drain3_rcount",    32'(rcount),    32'd0);
        check("drain3_rempty",    32'(rempty),    32'd1);
        check("drain3_raempty",   32'(raempty),   32'd1);
        check("drain3_rptr_gray", 32'(rptr_gray), 32'h2);
        check("drain3_rundf",     32'(rundf),     32'd0);

        // Underflow: request while empty
        tick();
        rinc = 1'b0;
        check("undf_rundf",     32'(rundf),     32'd1);
        check("undf_raddr",     32'(raddr),     32'd3);
        check("undf_rptr_gray", 32'(rptr_gray), 32'h2);
        check("undf_rempty",    32'(rempty),    32'd1);

        // Sticky through normal reads
        rq2_wptr = gray_tab[5];
        tick();
        check("post_undf_rcount", 32'(rcount), 32'd2);
        rinc = 1'b1;
        tick();
        tick();
        rinc = 1'b0;
        check("post_undf_raddr",  32'(raddr),  32'd5);
        check("post_undf_rempty", 32'(rempty), 32'd1);
        check("post_undf_rundf",  32'(rundf),  32'd1);

        // Reset clears rundf
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        check_reset_state("rst2");

        // Wrap: read 16 entries while the writer stays ahead
        rq2_wptr = gray_tab[4];
        tick();
        check("wrap_pre_rcount", 32'(rcount), 32'd4);
        for (int k = 0; k < 16; k++) begin
            wi = (k + 5 < 9) ? k + 5 : 9;
            if (k >= 8) wi = (k + 2 < 16) ? k + 2 : 16;
            rq2_wptr = gray_tab[wi % 16];
            rinc     = 1'b1;
            tick();
            if (k == 0) check("wrap_k0_rcount", 32'(rcount), 32'd4);
            if (k == 7) begin
                check("wrap8_rptr_gray", 32'(rptr_gray), 32'hC);
                check("wrap8_raddr",     32'(raddr),     32'd0);
                check("wrap8_rempty",    32'(rempty),    32'd0);
                check("wrap8_rcount",    32'(rcount),    32'd1);
                check("wrap8_raempty",   32'(raempty),   32'd1);
            end
        end
        rinc = 1'b0;
        check("wrap16_rptr_gray", 32'(rptr_gray), 32'd0);
        check("wrap16_rempty",    32'(rempty),    32'd1);
        check("wrap16_rcount",    32'(rcount),    32'd0);
        check("wrap16_raddr",     32'(raddr),     32'd0);

        // Reset mid-operation with a read pending
        rq2_wptr = gray_tab[2];
        tick();
        check("mid_pre_rcount", 32'(rcount), 32'd2);
        check("mid_pre_rempty", 32'(rempty), 32'd0);
        rinc = 1'b1;
        rrst = 1'b1;
        tick();
        rinc = 1'b0;
        rrst = 1'b0;
        check_reset_state("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
